// File: rtl/fir4_out_buf.sv
// Output buffer for the 4-tap FIR: scales the tap sum to a rounded mean, saturates to W bits,
// discards the first WARM strobes after reset, then queues samples in a FWFT FIFO.
module fir4_out_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int WARM  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W+1:0]             s_in,
  input  logic                     s_vld,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               ovf_cnt
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WCW = $clog2(WARM + 1);

  typedef enum logic {ST_WARM, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   warm_cnt_q, warm_cnt_d;
  logic             push_req;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       ovf_q, ovf_d;

  logic [W+2:0]     avg;
  logic [W-1:0]     sample;
  logic             is_full, pop, push_acc, drop;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WARM;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Next-state: the strobe that completes warm-up is itself discarded
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    if (state_q == ST_WARM && s_vld) begin
      warm_cnt_d = warm_cnt_q + WCW'(1);
      if (warm_cnt_d == WCW'(WARM)) state_d = ST_RUN;
    end
  end

  // FSM outputs
  always_comb begin
    push_req = 1'b0;
    if (state_q == ST_RUN) push_req = s_vld;
  end

  // Round half up, divide by 4, clamp to W bits
  assign avg    = ({1'b0, s_in} + (W+3)'(2)) >> 2;
  assign sample = (|avg[W+2:W]) ? '1 : avg[W-1:0];

  assign is_full  = (count_q == CW'(DEPTH));
  assign pop      = (count_q != '0) && out_ready;
  assign push_acc = push_req && (!is_full || pop);
  assign drop     = push_req && is_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_acc);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_acc) - CW'(pop);
    ovf_d    = ovf_q;
    if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // When full, a simultaneous pop frees the head slot, which is also the tail slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_acc) begin
      mem_q[wr_ptr_q] <= sample;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = (count_q == '0);
  assign ovf_cnt   = ovf_q;

endmodule
